decode_hazard_ctrl: RTL

//  Scoreboard and stall controller for the decode stage of the pipelined CPU (IF/ID/EX/MEM/WB, no forwarding).

---
 rtl/decode_hazard_ctrl_pkg.sv | 26 ++
 rtl/decode_hazard_ctrl_counter.sv | 41 ++++
 rtl/decode_hazard_ctrl.sv | 86 ++++++++
 3 files changed

// File: rtl/decode_hazard_ctrl_pkg.sv
// Shared constants and FSM encoding for the decode-stage scoreboard.
// Register-select width is architectural (3 bits); counter width is a top parameter.
package decode_hazard_ctrl_pkg;

  localparam int ARCH_REGS = 8;
  localparam int REG_SEL_W = 3;
  localparam logic [REG_SEL_W-1:0] R7_LINK = 3'd7;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } hz_state_e;

  // One-hot decode of a register select, gated by an enable.
  function automatic logic [ARCH_REGS-1:0] sel_onehot(
    input logic [REG_SEL_W-1:0] sel,
    input logic                 en
  );
    logic [ARCH_REGS-1:0] oh;
    oh = '0;
    if (en) oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/decode_hazard_ctrl_counter.sv
// Saturating up/down in-flight write counter for one architectural register.
// Increment and decrement in the same cycle cancel; overflow/underflow hold and pulse err.
module decode_hazard_ctrl_counter #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic nz,
  output logic one,
  output logic nz_next,
  output logic err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    err   = 1'b0;
    if (inc && !dec) begin
      if (cnt_q == CNT_MAX) err = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc) begin
      if (cnt_q == '0) err = 1'b1;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign nz      = |cnt_q;
  assign one     = (cnt_q == CNT_W'(1));
  assign nz_next = |cnt_d;

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage scoreboard: per-register in-flight write counters, RAW stall, halt drain.
// stall/issue are combinational from ID/WB inputs and registered state only.
module decode_hazard_ctrl
  import decode_hazard_ctrl_pkg::*;
#(
  parameter int NUM_REGS  = ARCH_REGS,
  parameter int CNT_W     = 2,
  parameter bit RF_BYPASS = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_SEL_W-1:0] id_rs_sel,
  input  logic                 id_rs_used,
  input  logic [REG_SEL_W-1:0] id_rt_sel,
  input  logic                 id_rt_used,
  input  logic [REG_SEL_W-1:0] id_wr_sel,
  input  logic                 id_wr_en,
  input  logic                 id_flush,
  input  logic                 halt_req,
  input  logic                 wb_wr_en,
  input  logic [REG_SEL_W-1:0] wb_wr_sel,
  output logic                 stall,
  output logic                 issue,
  output logic [NUM_REGS-1:0]  busy_mask,
  output logic                 halted,
  output logic                 err
);

  hz_state_e state_q;

  logic [NUM_REGS-1:0] inc_v, dec_v, nz_v, one_v, nzn_v, err_v, pend_v;
  logic [ARCH_REGS-1:0] inc_oh, dec_oh;
  logic hazard, in_run;

  assign inc_oh = sel_onehot(id_wr_sel, issue & id_wr_en);
  assign dec_oh = sel_onehot(wb_wr_sel, wb_wr_en);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
    assign inc_v[g] = inc_oh[g];
    assign dec_v[g] = dec_oh[g];
    // With rf bypass, the last outstanding write landing this cycle is readable now.
    assign pend_v[g] = nz_v[g] & ~(RF_BYPASS & one_v[g] & dec_v[g]);

    decode_hazard_ctrl_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc_v[g]),
      .dec     (dec_v[g]),
      .nz      (nz_v[g]),
      .one     (one_v[g]),
      .nz_next (nzn_v[g]),
      .err     (err_v[g])
    );
  end

  assign hazard = id_valid & ((id_rs_used & pend_v[id_rs_sel]) |
                              (id_rt_used & pend_v[id_rt_sel]));
  assign in_run = (state_q == ST_RUN);

  // Flush kills the ID slot outright, so it masks the hazard stall too.
  assign stall = in_run ? (hazard & ~id_flush) : 1'b1;
  assign issue = in_run & id_valid & ~id_flush & ~hazard;

  assign busy_mask = nz_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      halted  <= 1'b0;
      err     <= 1'b0;
    end else begin
      err <= err | (|err_v);
      case (state_q)
        ST_RUN:    if (issue && halt_req) state_q <= ST_DRAIN;
        ST_DRAIN:  if (!(|nzn_v)) begin
                     state_q <= ST_HALTED;
                     halted  <= 1'b1;
                   end
        ST_HALTED: state_q <= ST_HALTED;
        default:   state_q <= ST_RUN;
      endcase
    end
  end

endmodule
